// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the unified-memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   localparam int MEM_LAT_MAX = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between core and host requests.
// MEMARB_RR_EN selects round-robin on ties; otherwise host always wins.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic core_req_i,
   input  logic host_req_i,
`ifdef MEMARB_RR_EN
   input  logic last_host_i,
`endif
   output logic grant_o,
   output logic grant_host_o
);

   always_comb begin
      grant_o = core_req_i | host_req_i;
`ifdef MEMARB_RR_EN
      // On a tie the requester that did not own the memory last time wins.
      if (core_req_i && host_req_i) begin
         grant_host_o = ~last_host_i;
      end else begin
         grant_host_o = host_req_i;
      end
`else
      grant_host_o = host_req_i;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between the core and the host port.
// Define MEMARB_RR_EN for round-robin ties instead of fixed host priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)(
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_CoreReq,
   input  logic              i_CoreWe,
   input  logic [ADDR_W-1:0] i_CoreAddr,
   input  logic [DATA_W-1:0] i_CoreWData,
   output logic              o_CoreAck,
   output logic [DATA_W-1:0] o_CoreRData,
   output logic              o_CoreStall,
   input  logic              i_HostReq,
   input  logic              i_HostWe,
   input  logic [ADDR_W-1:0] i_HostAddr,
   input  logic [DATA_W-1:0] i_HostWData,
   output logic              o_HostAck,
   output logic [DATA_W-1:0] o_HostRData,
   output logic              o_MemEn,
   output logic              o_MemWe,
   output logic [ADDR_W-1:0] o_MemAddr,
   output logic [DATA_W-1:0] o_MemWData,
   input  logic [DATA_W-1:0] i_MemRData,
   output logic              o_Busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   generate
      if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
         $error("mem_arbiter: MEM_LAT out of range 1..8");
      end
   endgenerate

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic              grant;
   logic              grant_host;
`ifdef MEMARB_RR_EN
   logic              last_host_q;
`endif

   mem_arb_pick u_pick (
      .core_req_i   (i_CoreReq),
      .host_req_i   (i_HostReq),
`ifdef MEMARB_RR_EN
      .last_host_i  (last_host_q),
`endif
      .grant_o      (grant),
      .grant_host_o (grant_host)
   );

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_CORE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         host_rdata_q <= '0;
`ifdef MEMARB_RR_EN
         last_host_q  <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         host_rdata_q <= host_rdata_d;
`ifdef MEMARB_RR_EN
         if (state_q == IDLE && grant) begin
            last_host_q <= grant_host;
         end
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      host_rdata_d = host_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACCESS;
               cnt_d   = '0;
               if (grant_host) begin
                  owner_d = OWN_HOST;
                  we_d    = i_HostWe;
                  addr_d  = i_HostAddr;
                  wdata_d = i_HostWData;
               end else begin
                  owner_d = OWN_CORE;
                  we_d    = i_CoreWe;
                  addr_d  = i_CoreAddr;
                  wdata_d = i_CoreWData;
               end
            end
         end
         ACCESS: begin
            // Read data is only valid at the end of the last enabled cycle.
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               cnt_d   = '0;
               if (owner_q == OWN_HOST) begin
                  host_rdata_d = i_MemRData;
               end else begin
                  core_rdata_d = i_MemRData;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      o_MemEn   = (state_q == ACCESS);
      o_MemWe   = (state_q == ACCESS) && we_q;
      o_CoreAck = (state_q == RESP) && (owner_q == OWN_CORE);
      o_HostAck = (state_q == RESP) && (owner_q == OWN_HOST);
      o_Busy    = (state_q != IDLE);
   end

   assign o_MemAddr   = addr_q;
   assign o_MemWData  = wdata_q;
   assign o_CoreRData = core_rdata_q;
   assign o_HostRData = host_rdata_q;
   assign o_CoreStall = i_CoreReq & ~o_CoreAck;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

   localparam int L   = 3;
   localparam int BIG = 1000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic        host_req = 1'b0, host_we = 1'b0;
   logic [31:0] host_addr = '0, host_wdata = '0;
   logic        core_ack, core_stall, host_ack, mem_en, mem_we, busy;
   logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_CoreReq(core_req), .i_CoreWe(core_we), .i_CoreAddr(core_addr), .i_CoreWData(core_wdata),
      .o_CoreAck(core_ack), .o_CoreRData(core_rdata), .o_CoreStall(core_stall),
      .i_HostReq(host_req), .i_HostWe(host_we), .i_HostAddr(host_addr), .i_HostWData(host_wdata),
      .o_HostAck(host_ack), .o_HostRData(host_rdata),
      .o_MemEn(mem_en), .o_MemWe(mem_we), .o_MemAddr(mem_addr), .o_MemWData(mem_wdata),
      .i_MemRData(mem_rdata), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [3:0] i);
      return (i == 4'd0) ? 32'hDEADBEEF : {28'hA5A5A5A, i};
   endfunction

   // Bench memory: combinational read, write on every enabled write cycle.
   logic [31:0] bmem [16];
   logic [15:0] bvalid = '0;
   assign mem_rdata = bvalid[mem_addr[3:0]] ? bmem[mem_addr[3:0]] : init_word(mem_addr[3:0]);
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         bmem[mem_addr[3:0]]   <= mem_wdata;
         bvalid[mem_addr[3:0]] <= 1'b1;
      end
   end

   int total = 0, bad = 0, cyc = 0;
   logic auto_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one transaction at a time, timing from start cycle s.
   logic [31:0] mmem [16];
   bit          m_act = 0, m_host = 0, m_we = 0, m_last_host = 1;
   int          m_s = 0, free_at = 0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   int          ack_cyc_c = BIG, ack_cyc_h = BIG;
   logic        e_en = 0, e_we = 0, e_cack = 0, e_hack = 0, e_stall = 0, e_busy = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_crd = '0, e_hrd = '0;
   bit          e_crd_ok = 1, e_hrd_ok = 1;

   task automatic model_step();
      int k;
      k = cyc;
      if (rst) begin
         if (m_act && m_we && k >= m_s + 2) mmem[m_addr[3:0]] = m_wdata;
         m_act = 0; free_at = 0; m_last_host = 1;
         ack_cyc_c = BIG; ack_cyc_h = BIG;
         e_en = 0; e_we = 0; e_cack = 0; e_hack = 0; e_busy = 0;
         e_crd = '0; e_hrd = '0; e_crd_ok = 1; e_hrd_ok = 1;
         e_stall = core_req;
         return;
      end
      e_en   = m_act && k >= m_s + 1 && k <= m_s + L;
      e_we   = e_en && m_we;
      e_addr = m_addr;
      e_wdata = m_wdata;
      e_busy = m_act && k >= m_s + 1 && k <= m_s + L + 1;
      e_cack = m_act && k == m_s + L + 1 && !m_host;
      e_hack = m_act && k == m_s + L + 1 && m_host;
      if (m_act && k == m_s + L + 1) begin
         if (m_we) begin
            mmem[m_addr[3:0]] = m_wdata;
            if (m_host) e_hrd_ok = 0; else e_crd_ok = 0;
         end else if (m_host) begin
            e_hrd = mmem[m_addr[3:0]]; e_hrd_ok = 1;
         end else begin
            e_crd = mmem[m_addr[3:0]]; e_crd_ok = 1;
         end
         m_act = 0;
         free_at = k + 1;
      end
      e_stall = core_req && !e_cack;
      if (!m_act && k >= free_at && (core_req || host_req)) begin
`ifdef MEMARB_RR_EN
         m_host = (core_req && host_req) ? !m_last_host : host_req;
         m_last_host = m_host;
`else
         m_host = host_req;
`endif
         m_act = 1; m_s = k;
         m_we    = m_host ? host_we : core_we;
         m_addr  = m_host ? host_addr : core_addr;
         m_wdata = m_host ? host_wdata : core_wdata;
         if (m_host) ack_cyc_h = k + L + 1; else ack_cyc_c = k + L + 1;
      end
   endtask

   bit c_pend = 0, h_pend = 0;

   task automatic agents();
      if (c_pend) begin
         if (cyc == ack_cyc_c + 1) begin core_req = 0; c_pend = 0; ack_cyc_c = BIG; end
      end else if ($urandom_range(0, 3) == 0) begin
         core_req = 1; core_we = 1'($urandom_range(0, 1));
         core_addr = 32'($urandom_range(0, 15)); core_wdata = $urandom;
         c_pend = 1; ack_cyc_c = BIG;
      end
      if (h_pend) begin
         if (cyc == ack_cyc_h + 1) begin host_req = 0; h_pend = 0; ack_cyc_h = BIG; end
      end else if ($urandom_range(0, 4) == 0) begin
         host_req = 1; host_we = 1'($urandom_range(0, 1));
         host_addr = 32'($urandom_range(0, 15)); host_wdata = $urandom;
         h_pend = 1; ack_cyc_h = BIG;
      end
   endtask

   // Cycle k: count at the edge, drive at +1, model at +3, compare at negedge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (auto_en) agents();
      #2;
      model_step();
   end

   always @(negedge clk) begin
      checkb("mem_en", mem_en, e_en);
      checkb("mem_we", mem_we, e_we);
      checkb("core_ack", core_ack, e_cack);
      checkb("host_ack", host_ack, e_hack);
      checkb("core_stall", core_stall, e_stall);
      checkb("busy", busy, e_busy);
      if (e_en) begin
         check("mem_addr", mem_addr, e_addr);
         check("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_crd_ok) check("core_rdata", core_rdata, e_crd);
      if (e_hrd_ok) check("host_rdata", host_rdata, e_hrd);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mmem[i] = init_word(4'(i));
      repeat (3) step();
      checkb("rst_memen", mem_en, 1'b0);
      checkb("rst_busy", busy, 1'b0);
      check("rst_crdata", core_rdata, 32'h0);
      check("rst_memaddr", mem_addr, 32'h0);
      rst = 0;

      // Core read alone.
      step(); core_req = 1; core_we = 0; core_addr = 32'h10;
      step(); checkb("t1_en", mem_en, 1'b1); check("t1_addr", mem_addr, 32'h10);
      step(); step(); checkb("t1_stall", core_stall, 1'b1);
      step(); checkb("t1_ack", core_ack, 1'b1); check("t1_rdata", core_rdata, 32'hDEADBEEF);
      step(); core_req = 0;

      // Host write.
      step(); host_req = 1; host_we = 1; host_addr = 32'h40; host_wdata = 32'h12345678;
      for (int i = 1; i <= 3; i++) begin
         step();
         checkb("t2_we", mem_we, 1'b1);
         check("t2_addr", mem_addr, 32'h40);
         check("t2_wdata", mem_wdata, 32'h12345678);
      end
      step(); checkb("t2_hack", host_ack, 1'b1); checkb("t2_cack", core_ack, 1'b0);
      check("t2_crdata", core_rdata, 32'hDEADBEEF);
      step(); host_req = 0; host_we = 0;

      // Simultaneous requests.
      step(); core_req = 1; core_we = 0; core_addr = 32'h4;
      host_req = 1; host_we = 0; host_addr = 32'h8;
      repeat (4) step();
`ifdef MEMARB_RR_EN
      checkb("t3_first", core_ack, 1'b1);
      step(); core_req = 0;
      repeat (4) step();
      checkb("t3_second", host_ack, 1'b1);
      check("t3_hrdata", host_rdata, {28'hA5A5A5A, 4'h8});
      step(); host_req = 0;
`else
      checkb("t3_first", host_ack, 1'b1); checkb("t3_stall", core_stall, 1'b1);
      step(); host_req = 0;
      repeat (3) step(); checkb("t3_stall_hold", core_stall, 1'b1);
      step(); checkb("t3_second", core_ack, 1'b1);
      check("t3_crdata", core_rdata, {28'hA5A5A5A, 4'h4});
      step(); core_req = 0;
`endif

      // Core request held one cycle past its ack.
      step(); core_req = 1; core_we = 0; core_addr = 32'h5;
      repeat (4) step(); checkb("t4_ack1", core_ack, 1'b1);
      step(); checkb("t4_idle", busy, 1'b0);
      step(); checkb("t4_en2", mem_en, 1'b1);
      repeat (3) step(); checkb("t4_ack2", core_ack, 1'b1);
      step(); core_req = 0;

      // Reset in the second access cycle of a core write.
      step(); core_req = 1; core_we = 1; core_addr = 32'h6; core_wdata = 32'hCAFE0006;
      step(); step();
      rst = 1; #1;
      checkb("t5_en", mem_en, 1'b0); checkb("t5_we", mem_we, 1'b0); checkb("t5_busy", busy, 1'b0);
      core_req = 0; core_we = 0;
      step(); step(); checkb("t5_noack", core_ack, 1'b0);
      rst = 0;
      step(); core_req = 1; core_we = 0; core_addr = 32'h6;
      repeat (4) step(); checkb("t5_ack", core_ack, 1'b1);
      check("t5_rdata", core_rdata, 32'hCAFE0006);
      step(); core_req = 0;

      step();
      auto_en = 1;
      repeat (3000) step();
      auto_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
